// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums a group of unsigned 64-bit products from a 32x32 multiplier into an
// ACC_W-bit accumulator. A group is closed by a beat with in_last=1; the
// finished SUM/COUNT/OVF are then held on a valid/ready output until the
// consumer takes them, after which a new group starts from zero.
//
// Parameters
//   ACC_W  accumulator / SUM width in bits (64..128)
//   CNT_W  product-count width in bits
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of the current group (highest priority)
//   in_valid   P / in_last valid
//   in_ready   block can accept a product (registered)
//   P          unsigned 64-bit product
//   in_last    this product closes the group
//   out_valid  SUM / COUNT / OVF hold a completed group
//   out_ready  consumer accepts the result
//   SUM        accumulated sum (running value while out_valid=0)
//   COUNT      number of products in the group, saturating
//   OVF        sticky overflow of the ACC_W-bit sum
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      P,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] SUM,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVF
);

    localparam int SUM_W = ACC_W + 1;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             in_ready_p1;
    logic [ACC_W-1:0] acc_p1, acc_nxt;
    logic [CNT_W-1:0] cnt_p1, cnt_nxt;
    logic             ovf_p1, ovf_nxt;
    logic             accept;
    logic [SUM_W-1:0] sum_ext;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // One-bit-wider add so the carry out of bit ACC_W-1 is visible.
    function automatic logic [SUM_W-1:0] wide_add(input logic [ACC_W-1:0] a,
                                                  input logic [63:0]      p);
        return {1'b0, a} + SUM_W'(p);
    endfunction

    // in_ready comes straight from a flop, so out_ready never reaches it
    // combinationally and no beat is taken while the result is pending.
    assign accept  = in_valid & in_ready_p1 & ~clr;
    assign sum_ext = wide_add(acc_p1, P);

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc_p1;
        cnt_nxt   = cnt_p1;
        ovf_nxt   = ovf_p1;
        if (clr) begin
            state_nxt = ACCUM;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else if (state == ACCUM) begin
            if (accept) begin
                acc_nxt = sum_ext[ACC_W-1:0];
                ovf_nxt = ovf_p1 | sum_ext[ACC_W];
                cnt_nxt = sat_inc(cnt_p1);
                if (in_last) begin
                    state_nxt = DONE;
                end
            end
        end else begin
            if (out_ready) begin
                state_nxt = ACCUM;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                ovf_nxt   = 1'b0;
            end
        end
    end

    // Stage p1: group state register. in_ready stays low through reset and
    // rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            in_ready_p1 <= 1'b0;
            acc_p1      <= '0;
            cnt_p1      <= '0;
            ovf_p1      <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_p1 <= (state_nxt == ACCUM);
            acc_p1      <= acc_nxt;
            cnt_p1      <= cnt_nxt;
            ovf_p1      <= ovf_nxt;
        end
    end

    assign in_ready  = in_ready_p1;
    assign out_valid = (state == DONE);
    assign SUM       = acc_p1;
    assign COUNT     = cnt_p1;
    assign OVF       = ovf_p1;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_valid;
    logic [63:0] P;
    logic        in_last;
    logic        out_ready;

    logic        ir72, ov72, ovf72;
    logic [71:0] sum72;
    logic [7:0]  cnt72;
    logic        ir64, ov64, ovf64;
    logic [63:0] sum64;
    logic [7:0]  cnt64;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(72), .CNT_W(8)) dut72 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir72),
        .P(P), .in_last(in_last), .out_valid(ov72), .out_ready(out_ready),
        .SUM(sum72), .COUNT(cnt72), .OVF(ovf72)
    );

    product_accumulator #(.ACC_W(64), .CNT_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir64),
        .P(P), .in_last(in_last), .out_valid(ov64), .out_ready(out_ready),
        .SUM(sum64), .COUNT(cnt64), .OVF(ovf64)
    );

    // Behavioural reference: a group is "open" until its last beat is
    // accepted, then "done" until drained. Sums use wide plain arithmetic.
    logic [128:0] m_sum72, m_sum64;
    int           m_cnt;
    logic         m_ovf72, m_ovf64;
    logic         m_done;
    logic         m_started;

    task automatic model_reset();
        m_sum72 = '0; m_sum64 = '0; m_cnt = 0;
        m_ovf72 = 1'b0; m_ovf64 = 1'b0; m_done = 1'b0; m_started = 1'b0;
    endtask

    task automatic model_clear_group();
        m_sum72 = '0; m_sum64 = '0; m_cnt = 0;
        m_ovf72 = 1'b0; m_ovf64 = 1'b0; m_done = 1'b0;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic exp_ready;
        exp_ready = m_started && !m_done;
        chk("m_in_ready72",  128'(ir72),  128'(exp_ready));
        chk("m_in_ready64",  128'(ir64),  128'(exp_ready));
        chk("m_out_valid72", 128'(ov72),  128'(m_done));
        chk("m_out_valid64", 128'(ov64),  128'(m_done));
        chk("m_sum72",       128'(sum72), m_sum72[127:0]);
        chk("m_sum64",       128'(sum64), m_sum64[127:0]);
        chk("m_count72",     128'(cnt72), 128'(m_cnt));
        chk("m_count64",     128'(cnt64), 128'(m_cnt));
        chk("m_ovf72",       128'(ovf72), 128'(m_ovf72));
        chk("m_ovf64",       128'(ovf64), 128'(m_ovf64));
    endtask

    // Apply the currently driven inputs across one rising edge, advance the
    // model with the same inputs, then compare 1 time unit after the edge.
    task automatic cycle();
        logic accept;
        logic [128:0] t;
        accept = in_valid && m_started && !m_done && !clr;
        @(posedge clk);
        if (rst_n) begin
            if (clr) begin
                model_clear_group();
            end else if (accept) begin
                t = m_sum72 + 129'(P);
                if (t >= (129'd1 << 72)) m_ovf72 = 1'b1;
                m_sum72 = t % (129'd1 << 72);
                t = m_sum64 + 129'(P);
                if (t >= (129'd1 << 64)) m_ovf64 = 1'b1;
                m_sum64 = t % (129'd1 << 64);
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                if (in_last) m_done = 1'b1;
            end else if (m_done && out_ready) begin
                model_clear_group();
            end
            m_started = 1'b1;
        end
        #1;
        compare_model();
    endtask

    task automatic idle();
        clr = 1'b0; in_valid = 1'b0; P = '0; in_last = 1'b0; out_ready = 1'b0;
    endtask

    typedef struct {
        logic         v;
        logic [63:0]  p;
        logic         last;
        logic         c;
        logic         ord;
        logic [127:0] esum;
        logic [7:0]   ecnt;
        logic         eovf;
        logic         eov;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 64'hFFFFFFFE00000001, 1'b0, 1'b0, 1'b0, 128'hFFFFFFFE00000001,   8'd1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 64'hFFFFFFFE00000001, 1'b0, 1'b0, 1'b0, 128'h1FFFFFFFC00000002,  8'd2, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 64'hFFFFFFFE00000001, 1'b1, 1'b0, 1'b0, 128'h2FFFFFFFA00000003,  8'd3, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 64'h0,                1'b0, 1'b0, 1'b1, 128'h0,                  8'd0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 64'h7,                1'b0, 1'b0, 1'b0, 128'h7,                  8'd1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 64'h7,                1'b0, 1'b0, 1'b0, 128'hE,                  8'd2, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 64'h7,                1'b1, 1'b1, 1'b0, 128'h0,                  8'd0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 64'h2,                1'b1, 1'b0, 1'b0, 128'h2,                  8'd1, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 64'h9,                1'b1, 1'b0, 1'b0, 128'h2,                  8'd1, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 64'h0,                1'b0, 1'b0, 1'b1, 128'h0,                  8'd0, 1'b0, 1'b0};

        // Reset state, including in_ready held low until the first edge.
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", 128'(ov72), 128'd0);
        chk("rst_sum",       128'(sum72), 128'd0);
        chk("rst_count",     128'(cnt72), 128'd0);
        chk("rst_ovf",       128'(ovf72), 128'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready_low", 128'(ir72), 128'd0);
        cycle();
        chk("rst_in_ready_rise", 128'(ir72), 128'd1);

        // Table: three-beat sum, clear with concurrent beat, hold in DONE.
        for (int i = 0; i < 10; i++) begin
            in_valid = tbl[i].v; P = tbl[i].p; in_last = tbl[i].last;
            clr = tbl[i].c; out_ready = tbl[i].ord;
            cycle();
            chk($sformatf("tbl%0d_sum", i),       128'(sum72), tbl[i].esum);
            chk($sformatf("tbl%0d_count", i),     128'(cnt72), 128'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_ovf", i),       128'(ovf72), 128'(tbl[i].eovf));
            chk($sformatf("tbl%0d_out_valid", i), 128'(ov72),  128'(tbl[i].eov));
        end
        idle();

        // 64-bit accumulator wraps and flags overflow.
        in_valid = 1'b1; P = 64'h8000000000000000;
        cycle();
        in_last = 1'b1;
        cycle();
        idle();
        chk("ovf64_sum",   128'(sum64), 128'd0);
        chk("ovf64_count", 128'(cnt64), 128'd2);
        chk("ovf64_ovf",   128'(ovf64), 128'd1);
        chk("ovf64_valid", 128'(ov64),  128'd1);
        chk("ovf72_sum",   128'(sum72), 128'h10000000000000000);
        chk("ovf72_ovf",   128'(ovf72), 128'd0);
        out_ready = 1'b1;
        cycle();
        idle();

        // Single beat held under back-pressure; offered beats are ignored.
        in_valid = 1'b1; P = 64'h5; in_last = 1'b1;
        cycle();
        P = 64'h9;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold_sum",      128'(sum72), 128'd5);
            chk("hold_count",    128'(cnt72), 128'd1);
            chk("hold_in_ready", 128'(ir72),  128'd0);
            chk("hold_valid",    128'(ov72),  128'd1);
        end
        idle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("drain_in_ready", 128'(ir72), 128'd1);
        chk("drain_sum",      128'(sum72), 128'd0);
        chk("drain_valid",    128'(ov72),  128'd0);

        // Count saturation.
        for (int i = 0; i < 258; i++) begin
            in_valid = 1'b1; P = 64'h1; in_last = (i == 257);
            cycle();
        end
        idle();
        chk("sat_count", 128'(cnt72), 128'd255);
        chk("sat_sum",   128'(sum72), 128'd258);
        chk("sat_ovf",   128'(ovf72), 128'd0);
        chk("sat_valid", 128'(ov72),  128'd1);
        out_ready = 1'b1;
        cycle();
        idle();

        // Asynchronous reset between edges while a result is pending.
        in_valid = 1'b1; P = 64'h3; in_last = 1'b1;
        cycle();
        idle();
        chk("areset_pre_valid", 128'(ov72), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("areset_valid",    128'(ov72),  128'd0);
        chk("areset_sum",      128'(sum72), 128'd0);
        chk("areset_in_ready", 128'(ir72),  128'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("areset_ready_low", 128'(ir72), 128'd0);
        cycle();
        chk("areset_ready_rise", 128'(ir72), 128'd1);
        chk("areset_no_stale",   128'(ov72), 128'd0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            clr       = ($urandom_range(0, 31) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            P         = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) P = 64'hFFFFFFFFFFFFFFFF - 64'($urandom_range(0, 15));
            cycle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
